// File: rtl/sdpmem_be_clr_pkg.sv
// Shared types and helpers for the byte-enable simple dual-port RAM with clear engine.
// Holds the clear FSM state encoding and the lane-count computation.
package sdpmem_be_clr_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    function automatic int nlanes(input int width, input int lane_width);
        return width / lane_width;
    endfunction

endpackage

// File: rtl/sdpmem_be_clr_lane.sv
// One byte-enable lane of the RAM: LANE_WIDTH bits wide, 2**DEPTH words deep.
// Synchronous write on a strobe, asynchronous read; contents are never reset.
module sdpmem_be_clr_lane #(
    parameter int DEPTH      = 6,
    parameter int LANE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH-1:0]      waddr,
    input  logic [LANE_WIDTH-1:0] wdata,
    input  logic [DEPTH-1:0]      raddr,
    output logic [LANE_WIDTH-1:0] rdata
);

    logic [LANE_WIDTH-1:0] mem_q [2**DEPTH];

    // storage write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sdpmem_be_clr.sv
// Simple dual-port RAM with per-lane byte enables, selectable read latency,
// optional read-during-write forwarding and a hardware zero-clear engine.
module sdpmem_be_clr
    import sdpmem_be_clr_pkg::*;
#(
    parameter int DEPTH          = 6,
    parameter int WIDTH          = 32,
    parameter int LANE_WIDTH     = 8,
    parameter int READ_LAT       = 1,
    parameter int BYPASS         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  clr,
    output logic                                  busy,
    input  logic                                  ena,
    input  logic                                  wea,
    input  logic [nlanes(WIDTH, LANE_WIDTH)-1:0]  bea,
    input  logic [DEPTH-1:0]                      addra,
    input  logic [WIDTH-1:0]                      dia,
    input  logic                                  enb,
    input  logic [DEPTH-1:0]                      addrb,
    output logic [WIDTH-1:0]                      dob,
    output logic                                  dob_valid
);

    localparam int NLANES = nlanes(WIDTH, LANE_WIDTH);
    localparam logic [DEPTH-1:0] LAST_ADDR = {DEPTH{1'b1}};
    localparam clr_state_e RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    clr_state_e        state_q, state_d;
    logic [DEPTH-1:0]  cnt_q, cnt_d;
    logic              busy_s;
    logic              user_wr_s;
    logic [NLANES-1:0] user_lane_we_s;
    logic [NLANES-1:0] lane_we_s;
    logic [DEPTH-1:0]  waddr_s;
    logic [WIDTH-1:0]  wdata_s;
    logic [WIDTH-1:0]  rdata_s;

    // busy is taken straight from the state flop so it is glitch-free
    assign busy_s         = (state_q == ST_CLEAR);
    assign busy           = busy_s;
    assign user_wr_s      = ena & wea & ~busy_s & ~clr;
    assign user_lane_we_s = bea & {NLANES{user_wr_s}};

    // clear FSM next-state and address counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (clr) begin
                    state_d = ST_CLEAR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                cnt_d = cnt_q + DEPTH'(1);
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            default: begin
                state_d = RST_STATE;
                cnt_d   = '0;
            end
        endcase
    end

    // clear FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // write port mux: the clear engine owns every lane while busy
    always_comb begin
        if (busy_s) begin
            lane_we_s = {NLANES{1'b1}};
            waddr_s   = cnt_q;
            wdata_s   = '0;
        end else begin
            lane_we_s = user_lane_we_s;
            waddr_s   = addra;
            wdata_s   = dia;
        end
    end

    for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
        sdpmem_be_clr_lane #(
            .DEPTH      (DEPTH),
            .LANE_WIDTH (LANE_WIDTH)
        ) u_lane (
            .clk   (clk),
            .we    (lane_we_s[gi]),
            .waddr (waddr_s),
            .wdata (wdata_s[gi*LANE_WIDTH +: LANE_WIDTH]),
            .raddr (addrb),
            .rdata (rdata_s[gi*LANE_WIDTH +: LANE_WIDTH])
        );
    end

    if ((WIDTH % LANE_WIDTH) != 0) begin : g_bad_width
        $error("sdpmem_be_clr: WIDTH must be a multiple of LANE_WIDTH");
    end

    if (READ_LAT == 0) begin : g_lat0
        assign dob       = rdata_s;
        assign dob_valid = enb & ~busy_s;
    end else if (READ_LAT == 1) begin : g_lat1
        logic [WIDTH-1:0] fwd_s;
        logic [WIDTH-1:0] dob_q, dob_d;
        logic             dob_valid_q, dob_valid_d;

        // same-address forwarding of the lanes being written this cycle
        always_comb begin
            fwd_s = rdata_s;
            for (int i = 0; i < NLANES; i++) begin
                if ((BYPASS != 0) && user_lane_we_s[i] && (addra == addrb)) begin
                    fwd_s[i*LANE_WIDTH +: LANE_WIDTH] = dia[i*LANE_WIDTH +: LANE_WIDTH];
                end else begin
                    fwd_s[i*LANE_WIDTH +: LANE_WIDTH] = rdata_s[i*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end

        // read register next value: hold data, drop the qualifier when idle or busy
        always_comb begin
            if (enb && !busy_s) begin
                dob_d       = fwd_s;
                dob_valid_d = 1'b1;
            end else begin
                dob_d       = dob_q;
                dob_valid_d = 1'b0;
            end
        end

        // read data register
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dob_q       <= '0;
                dob_valid_q <= 1'b0;
            end else begin
                dob_q       <= dob_d;
                dob_valid_q <= dob_valid_d;
            end
        end

        assign dob       = dob_q;
        assign dob_valid = dob_valid_q;
    end else begin : g_bad_lat
        $error("sdpmem_be_clr: READ_LAT must be 0 or 1");
    end

endmodule

// File: tb/tb_sdpmem_be_clr.sv
// Directed self-checking bench: three instances share one stimulus bus
// (registered+bypass, registered without bypass, combinational read).
module tb_sdpmem_be_clr;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        ena;
    logic        wea;
    logic [3:0]  bea;
    logic [3:0]  addra;
    logic [31:0] dia;
    logic        enb;
    logic [3:0]  addrb;

    logic        busy_a, busy_n, busy_0;
    logic [31:0] dob_a, dob_n, dob_0;
    logic        val_a, val_n, val_0;

    int n_checks = 0;
    int n_fail   = 0;

    sdpmem_be_clr #(.DEPTH(4), .WIDTH(32), .LANE_WIDTH(8), .READ_LAT(1), .BYPASS(1), .CLEAR_ON_RESET(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy_a), .ena(ena), .wea(wea), .bea(bea),
        .addra(addra), .dia(dia), .enb(enb), .addrb(addrb), .dob(dob_a), .dob_valid(val_a)
    );

    sdpmem_be_clr #(.DEPTH(4), .WIDTH(32), .LANE_WIDTH(8), .READ_LAT(1), .BYPASS(0), .CLEAR_ON_RESET(1)) u_nobyp (
        .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy_n), .ena(ena), .wea(wea), .bea(bea),
        .addra(addra), .dia(dia), .enb(enb), .addrb(addrb), .dob(dob_n), .dob_valid(val_n)
    );

    sdpmem_be_clr #(.DEPTH(4), .WIDTH(32), .LANE_WIDTH(8), .READ_LAT(0), .BYPASS(1), .CLEAR_ON_RESET(1)) u_lat0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy_0), .ena(ena), .wea(wea), .bea(bea),
        .addra(addra), .dia(dia), .enb(enb), .addrb(addrb), .dob(dob_0), .dob_valid(val_0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        ena = 1'b1; wea = 1'b1; addra = a; dia = d; bea = be;
        tick();
        ena = 1'b0; wea = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
        addrb = a; enb = 1'b1;
        #1;
        chk_eq({tag, " lat0 dob"}, dob_0, exp);
        chk_eq({tag, " lat0 valid"}, {31'd0, val_0}, 32'd1);
        tick();
        chk_eq({tag, " byp dob"}, dob_a, exp);
        chk_eq({tag, " byp valid"}, {31'd0, val_a}, 32'd1);
        chk_eq({tag, " nobyp dob"}, dob_n, exp);
        enb = 1'b0;
    endtask

    task automatic measure_busy(output int n);
        n = 0;
        while (busy_a && n < 100) begin
            n++;
            tick();
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0; clr = 1'b0; ena = 1'b0; wea = 1'b0; bea = 4'h0;
        addra = 4'd0; dia = 32'd0; enb = 1'b0; addrb = 4'd0;

        // 1: reset state, busy length, cleared contents
        repeat (3) tick();
        chk_eq("rst busy", {31'd0, busy_a}, 32'd1);
        chk_eq("rst dob", dob_a, 32'd0);
        chk_eq("rst valid", {31'd0, val_a}, 32'd0);
        rst_n = 1'b1;
        measure_busy(n);
        chk_eq("init busy cycles", n, 32'd16);
        chk_eq("init busy lat0", {31'd0, busy_0}, 32'd0);
        addrb = 4'd0; enb = 1'b1;
        #1;
        chk_eq("valid before edge", {31'd0, val_a}, 32'd0);
        for (int i = 0; i < 16; i++) rd($sformatf("init rd%0d", i), 4'(i), 32'd0);

        // 2: partial lane update
        wr(4'd3, 32'hDEADBEEF, 4'b1111);
        wr(4'd3, 32'h00005500, 4'b0010);
        rd("lane rd3", 4'd3, 32'hDEAD55EF);

        // 3: read during write, full and partial lanes, then different addresses
        ena = 1'b1; wea = 1'b1; bea = 4'b1111; addra = 4'd5; dia = 32'h12345678;
        enb = 1'b1; addrb = 4'd5;
        #1;
        chk_eq("rdw lat0 old", dob_0, 32'd0);
        tick();
        chk_eq("rdw byp", dob_a, 32'h12345678);
        chk_eq("rdw nobyp", dob_n, 32'd0);
        ena = 1'b0; wea = 1'b0; enb = 1'b0;
        rd("rdw after", 4'd5, 32'h12345678);
        ena = 1'b1; wea = 1'b1; bea = 4'b0101; addra = 4'd3; dia = 32'h11223344;
        enb = 1'b1; addrb = 4'd3;
        tick();
        chk_eq("rdw part byp", dob_a, 32'hDE225544);
        chk_eq("rdw part nobyp", dob_n, 32'hDEAD55EF);
        addra = 4'd6; dia = 32'h0BADF00D; bea = 4'b1111; addrb = 4'd5;
        tick();
        chk_eq("diff addr byp", dob_a, 32'h12345678);
        ena = 1'b0; wea = 1'b0; enb = 1'b0;
        rd("diff addr rd6", 4'd6, 32'h0BADF00D);

        // 4: clear request with writes and a second clr during busy
        for (int i = 0; i < 16; i++) wr(4'(i), 32'h01010101 * (i + 1), 4'b1111);
        rd("fill rd7", 4'd7, 32'h08080808);
        clr = 1'b1; ena = 1'b1; wea = 1'b1; bea = 4'b1111; addra = 4'd0; dia = 32'hFFFFFFFF;
        enb = 1'b1; addrb = 4'd7;
        tick();
        clr = 1'b0; ena = 1'b0; wea = 1'b0;
        chk_eq("clr busy rise", {31'd0, busy_a}, 32'd1);
        n = 0;
        while (busy_a && n < 100) begin
            n++;
            if (n == 5) begin
                clr = 1'b1; ena = 1'b1; wea = 1'b1; addra = 4'd2; dia = 32'hFFFFFFFF;
            end
            if (n == 6) begin
                clr = 1'b0; ena = 1'b0; wea = 1'b0;
            end
            if (n == 8) begin
                chk_eq("busy valid", {31'd0, val_a}, 32'd0);
                chk_eq("busy dob hold", dob_a, 32'h08080808);
                chk_eq("busy lat0 valid", {31'd0, val_0}, 32'd0);
            end
            tick();
        end
        enb = 1'b0; clr = 1'b0; ena = 1'b0; wea = 1'b0;
        chk_eq("clr busy cycles", n, 32'd16);
        for (int i = 0; i < 16; i++) rd($sformatf("clr rd%0d", i), 4'(i), 32'd0);

        // 5: reset in the middle of a clear
        wr(4'd1, 32'hCAFEF00D, 4'b1111);
        rd("pre rst rd1", 4'd1, 32'hCAFEF00D);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (7) tick();
        chk_eq("mid clr hold", dob_a, 32'hCAFEF00D);
        rst_n = 1'b0;
        #1;
        chk_eq("mid rst dob", dob_a, 32'd0);
        chk_eq("mid rst valid", {31'd0, val_a}, 32'd0);
        chk_eq("mid rst nobyp dob", dob_n, 32'd0);
        chk_eq("mid rst busy", {31'd0, busy_a}, 32'd1);
        repeat (2) tick();
        rst_n = 1'b1;
        measure_busy(n);
        chk_eq("rerun busy cycles", n, 32'd16);
        for (int i = 0; i < 16; i++) rd($sformatf("rerun rd%0d", i), 4'(i), 32'd0);

        // 6: combinational read path
        addrb = 4'd9; enb = 1'b0;
        #1;
        chk_eq("lat0 pre wr", dob_0, 32'd0);
        chk_eq("lat0 valid off", {31'd0, val_0}, 32'd0);
        wr(4'd9, 32'hA5A5A5A5, 4'b1111);
        chk_eq("lat0 after wr", dob_0, 32'hA5A5A5A5);
        enb = 1'b1;
        #1;
        chk_eq("lat0 valid on", {31'd0, val_0}, 32'd1);
        chk_eq("lat0 dob on", dob_0, 32'hA5A5A5A5);
        enb = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
